// File: rtl/bnn_accum_binarize_if.sv
// Handshake bundle between the conv stage, the accumulate/binarize block and the downstream consumer.
// master drives beats, threshold, clear and out_ready; slave is the accumulate/binarize block.
interface bnn_accum_binarize_if #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic [ACC_WIDTH-1:0] thresh;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_bit;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 busy;

    modport master (
        output in_valid, in_data, thresh, clear, out_ready,
        input  in_ready, out_valid, out_bit, out_sum, busy
    );

    modport slave (
        input  in_valid, in_data, thresh, clear, out_ready,
        output in_ready, out_valid, out_bit, out_sum, busy
    );
endinterface

// File: rtl/bnn_accum_binarize.sv
// Sums CH_CNT signed partial sums per pixel and binarizes against a threshold (BNN_ACC_SAT_EN: saturating add).
// Latency: result registered on the beat completing the group, out_valid visible the following cycle.
// Backpressure: while a result is held, in_ready follows out_ready; a handshake may start the next group.
module bnn_accum_binarize #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CH_CNT    = 16,
    parameter int CNT_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bnn_accum_binarize_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] thr_q, thr_d;
    logic                 out_vld_q, out_vld_d;
    logic                 out_bit_q, out_bit_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;

    logic                 beat;
    logic [ACC_WIDTH-1:0] beat_ext;
    logic [ACC_WIDTH-1:0] acc_sum;

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
`ifdef BNN_ACC_SAT_EN
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        // Extra sign bit disagreeing with the result sign means the add left the representable range.
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    assign bus.in_ready  = (state_q == HOLD) ? bus.out_ready : 1'b1;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_vld_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_sum   = out_sum_q;

    assign beat     = bus.in_valid && bus.in_ready;
    assign beat_ext = ACC_WIDTH'($signed(bus.in_data));
    assign acc_sum  = acc_add(acc_q, beat_ext);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        out_vld_d = out_vld_q;
        out_bit_d = out_bit_q;
        out_sum_d = out_sum_q;

        if (bus.clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d   = beat_ext;
                        thr_d   = bus.thresh;
                        cnt_d   = CNT_W'(1);
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = acc_sum;
                        if (cnt_q == CNT_W'(CH_CNT - 1)) begin
                            out_sum_d = acc_sum;
                            out_bit_d = ($signed(acc_sum) >= $signed(thr_q));
                            out_vld_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // in_ready == out_ready here, so a beat implies the result handshake.
                    if (out_vld_q && bus.out_ready) begin
                        out_vld_d = 1'b0;
                        if (beat) begin
                            acc_d   = beat_ext;
                            thr_d   = bus.thresh;
                            cnt_d   = CNT_W'(1);
                            state_d = ACC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            thr_q     <= '0;
            out_vld_q <= 1'b0;
            out_bit_q <= 1'b0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            thr_q     <= thr_d;
            out_vld_q <= out_vld_d;
            out_bit_q <= out_bit_d;
            out_sum_q <= out_sum_d;
        end
    end
endmodule

// File: tb/tb_bnn_accum_binarize.sv
// Directed bench: default 16-bit instance for function/handshake/reset, 10-bit instance for overflow.
module tb_bnn_accum_binarize;
    typedef logic signed [31:0] v_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bnn_accum_binarize_if #(.IN_WIDTH(8), .ACC_WIDTH(16)) bus ();
    bnn_accum_binarize_if #(.IN_WIDTH(8), .ACC_WIDTH(10)) bus2 ();

    bnn_accum_binarize #(.IN_WIDTH(8), .ACC_WIDTH(16), .CH_CNT(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    bnn_accum_binarize #(.IN_WIDTH(8), .ACC_WIDTH(10), .CH_CNT(16), .CNT_W(4)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input v_t obs, input v_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n beats with out_ready=1; threshold only valid on the first beat, then perturbed.
    task automatic run_group(input string tag, input int n, input logic signed [7:0] d,
                             input logic signed [15:0] thr, input v_t exp_sum, input v_t exp_bit);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.thresh   = (i == 0) ? thr : ~thr;
            tick();
            if (i < n - 1) check({tag, "_vld_early"}, v_t'(bus.out_valid), 0);
        end
        check({tag, "_vld"}, v_t'(bus.out_valid), 1);
        check({tag, "_sum"}, $signed(bus.out_sum), exp_sum);
        check({tag, "_bit"}, v_t'(bus.out_bit), exp_bit);
        bus.in_valid = 1'b0;
        tick();
        check({tag, "_vld_drop"}, v_t'(bus.out_valid), 0);
        check({tag, "_idle"}, v_t'(bus.busy), 0);
    endtask

    initial begin
        int first_idx, second_idx, n_res, rdy_low;
        v_t sum1, sum2;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.thresh = '0; bus.clear = 1'b0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.thresh = '0; bus2.clear = 1'b0; bus2.out_ready = 1'b1;
        #3;
        check("rst_vld", v_t'(bus.out_valid), 0);
        check("rst_sum", $signed(bus.out_sum), 0);
        check("rst_bit", v_t'(bus.out_bit), 0);
        check("rst_rdy", v_t'(bus.in_ready), 1);
        check("rst_busy", v_t'(bus.busy), 0);
        #5 rst_n = 1'b1;
        tick();

        // 16 x +3 against 40; single-cycle out_valid pulse.
        run_group("pos", 16, 8'sd3, 16'sd40, 48, 1);
        // 16 x -8: below 0, equal to -128.
        run_group("neg", 16, -8'sd8, 16'sd0, -128, 0);
        run_group("eq", 16, -8'sd8, -16'sd128, -128, 1);

        // Backpressure: result held while out_ready low, pending beat not lost.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'sd2; bus.thresh = '0;
            tick();
        end
        bus.in_data = 8'sd5; bus.thresh = '0;
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", v_t'(bus.out_valid), 1);
            check("bp_sum", $signed(bus.out_sum), 32);
            check("bp_rdy", v_t'(bus.in_ready), 0);
            tick();
        end
        check("bp_bit", v_t'(bus.out_bit), 1);
        bus.out_ready = 1'b1;
        #1 check("bp_rdy_up", v_t'(bus.in_ready), 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.thresh = 16'sd127;
            if (i == 0) check("bp_restart_busy", v_t'(bus.busy), 1);
            if (i < 15) check("bp2_vld_early", v_t'(bus.out_valid), 0);
        end
        check("bp2_vld", v_t'(bus.out_valid), 1);
        check("bp2_sum", $signed(bus.out_sum), 80);
        check("bp2_bit", v_t'(bus.out_bit), 1);
        bus.in_valid = 1'b0;
        tick();

        // Back-to-back: 32 continuous beats of +1.
        first_idx = -1; second_idx = -1; n_res = 0; rdy_low = 0; sum1 = 0; sum2 = 0;
        bus.thresh = '0;
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'sd1;
            if (bus.in_ready !== 1'b1) rdy_low++;
            tick();
            if (bus.out_valid === 1'b1) begin
                n_res++;
                if (first_idx < 0) begin first_idx = i; sum1 = $signed(bus.out_sum); end
                else begin second_idx = i; sum2 = $signed(bus.out_sum); end
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_results", n_res, 2);
        check("b2b_first_idx", first_idx, 15);
        check("b2b_spacing", second_idx - first_idx, 16);
        check("b2b_sum1", sum1, 16);
        check("b2b_sum2", sum2, 16);
        check("b2b_rdy_low", rdy_low, 0);
        tick();

        // Asynchronous reset mid-group.
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'sd5;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", v_t'(bus.out_valid), 0);
        check("arst_sum", $signed(bus.out_sum), 0);
        check("arst_bit", v_t'(bus.out_bit), 0);
        check("arst_busy", v_t'(bus.busy), 0);
        check("arst_rdy", v_t'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        run_group("post_rst", 16, 8'sd1, 16'sd0, 16, 1);

        // Clear after 3 beats, with a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'sd7;
            tick();
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        check("clr_busy", v_t'(bus.busy), 0);
        run_group("post_clr", 16, 8'sd1, 16'sd0, 16, 1);

        // 10-bit accumulator overflow.
        for (int i = 0; i < 16; i++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 8'sd127;
            tick();
        end
        bus2.in_valid = 1'b0;
        check("ovf_vld", v_t'(bus2.out_valid), 1);
`ifdef BNN_ACC_SAT_EN
        check("ovf_sum", $signed(bus2.out_sum), 511);
`else
        check("ovf_sum", $signed(bus2.out_sum), -16);
`endif
        tick();
        check("ovf_vld_drop", v_t'(bus2.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bnn_accum_binarize.md
BNN_ACCUM_BINARIZE -- requirements
Module: bnn_accum_binarize

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, width of each signed partial sum from the conv stage (DATA_WIDTH+LOGK).
REQ-002 SHALL have parameter ACC_WIDTH, default 16, width of the signed accumulator and threshold.
REQ-003 SHALL have parameter CH_CNT, default 16, number of input-channel partial sums per output pixel (CH_CNT >= 2).
REQ-004 SHALL have parameter CNT_W, default 4, beat-counter width (2**CNT_W >= CH_CNT).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, in_data beat valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-009 SHALL have port in_data, input, IN_WIDTH, signed two's-complement partial sum.
REQ-010 SHALL have port thresh, input, ACC_WIDTH, signed binarization threshold.
REQ-011 SHALL have port clear, input, 1, synchronous flush of the group in progress.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port out_bit, output, 1, binary activation (1 = +1, 0 = -1).
REQ-015 SHALL have port out_sum, output, ACC_WIDTH, signed accumulated sum of the group.
REQ-016 SHALL have port busy, output, 1, high when not IDLE.

Function
REQ-017 SHALL implement states IDLE, ACC and HOLD.
REQ-018 SHALL define a beat as accepted when in_valid and in_ready are both high on a rising edge.
REQ-019 SHALL drive in_ready high in IDLE and ACC; in HOLD, in_ready SHALL equal out_ready.
REQ-020 SHALL, in IDLE on an accepted beat, load acc = sign-extended in_data, latch thresh, set count=1, and go to ACC.
REQ-021 SHALL, in ACC, add each accepted sign-extended beat to acc and increment count; thresh changes SHALL be ignored.
REQ-022 SHALL, on the beat that makes count equal CH_CNT, register out_sum = final acc, out_bit = (out_sum >= latched thresh, signed), assert out_valid on the next cycle, and enter HOLD.
REQ-023 SHALL hold out_valid, out_sum and out_bit stable in HOLD until out_valid and out_ready are both high.
REQ-024 SHALL, on a HOLD handshake without an accepted beat, deassert out_valid and go to IDLE.
REQ-025 SHALL, on a HOLD handshake with an accepted beat in the same cycle, start a new group from that beat (as in REQ-020) and go to ACC, with no bubble.
REQ-026 SHALL, on clear high, zero acc and count and go to IDLE; in HOLD, clear SHALL also drop out_valid, and clear SHALL take priority over any accepted beat.
REQ-027 SHALL insert no idle cycles while in_valid is held high; throughput SHALL be one beat per cycle.
REQ-028 SHALL wrap two's-complement on accumulator overflow unless REQ-033 applies.

Reset
REQ-029 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, acc=0, count=0, latched thresh=0, out_valid=0, out_bit=0 and out_sum=0.
REQ-030 SHALL discard any partial group on reset mid-operation; the first group after reset release SHALL sum from zero.
REQ-031 SHALL drive in_ready=1 and busy=0 after reset.

Configuration
REQ-032 SHALL use macro BNN_ACC_SAT_EN to select the accumulator overflow behaviour.
REQ-033 SHALL, with BNN_ACC_SAT_EN defined, clamp each addition to [-(2**(ACC_WIDTH-1)), 2**(ACC_WIDTH-1)-1]; the clamp is sticky, with later beats added to the clamped value.
REQ-034 SHALL, with BNN_ACC_SAT_EN undefined, perform plain ACC_WIDTH-bit wrap-around addition.

Verification
REQ-035 SHALL cover: 16 beats of +3, thresh=40, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after beat 16, out_sum=48, out_bit=1.
REQ-036 SHALL cover: 16 beats of -8, thresh=0 -> out_sum=-128, out_bit=0; thresh=-128 on the first beat -> out_bit=1 (equality).
REQ-037 SHALL cover backpressure: group completes, out_ready low for 5 cycles -> out_valid and data stable, in_ready=0, no beats lost; after out_ready rises, the next group is correct.
REQ-038 SHALL cover back-to-back: 32 continuous beats of +1 with out_ready=1 -> two results of 16, the second exactly 16 cycles after the first, in_ready never low.
REQ-039 SHALL cover reset mid-group: rst_n pulsed low after 7 beats of +5 -> all outputs 0 immediately; next 16 beats of +1 -> out_sum=16; clear after 3 beats behaves the same.
REQ-040 SHALL cover ACC_WIDTH=10 with 16 beats of +127 -> out_sum=511 with BNN_ACC_SAT_EN and out_sum=-16 without it.
